// File: rtl/bramac_pkg.sv
// Shared types for the BRAMAC dummy-array controller.
// States, row addresses, write-select codes and the strobe bundle.
package bramac_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ACC,
    S_COPY,
    S_PREADD,
    S_BUBBLE,
    S_INV,
    S_SUB,
    S_ASL,
    S_ACC,
    S_WAIT,
    S_DONE_1,
    S_DONE_2
  } state_t;

  localparam logic [2:0] ROW_ZERO = 3'd0;
  localparam logic [2:0] ROW_W1   = 3'd1;
  localparam logic [2:0] ROW_W2   = 3'd2;
  localparam logic [2:0] ROW_W12  = 3'd3;
  localparam logic [2:0] ROW_INV  = 3'd4;
  localparam logic [2:0] ROW_PSUM = 3'd5;
  localparam logic [2:0] ROW_ACC  = 3'd6;

  // 0 is reserved for "no write" so idle selects read as 0
  localparam logic [1:0] WSEL_NONE = 2'd0;
  localparam logic [1:0] WSEL_ZERO = 2'd1;
  localparam logic [1:0] WSEL_BRAM = 2'd2;
  localparam logic [1:0] WSEL_ALU  = 2'd3;

  typedef struct packed {
    logic       carry_in;
    logic       ren_1;
    logic       ren_2;
    logic       wen_1;
    logic       wen_2;
    logic       readout;
    logic       mac_done;
    logic [2:0] raddr_1;
    logic [2:0] raddr_2;
    logic [2:0] waddr_1;
    logic [2:0] waddr_2;
    logic [1:0] wsel_1;
    logic [1:0] wsel_2;
  } strobes_t;

  function automatic logic [2:0] act_dec(
    input logic msb_1,
    input logic msb_2
  );
    return {1'b0, msb_2, msb_1};
  endfunction

endpackage

// File: rtl/bramac_act_shreg.sv
// Activation shift register: right-aligned inputs are stored
// left-aligned so the current bit is always the MSB.
module bramac_act_shreg #(
  parameter int PREC_MAX = 8,
  parameter int PW       = $clog2(PREC_MAX) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [PW-1:0]       prec,
  input  logic [PREC_MAX-1:0] act_1,
  input  logic [PREC_MAX-1:0] act_2,
  output logic                msb_1,
  output logic                msb_2
);

  logic [PREC_MAX-1:0] a1_q;
  logic [PREC_MAX-1:0] a2_q;
  logic [PW-1:0]       lsh;

  assign lsh = PW'(PREC_MAX) - prec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
    end else if (load) begin
      a1_q <= act_1 << lsh;
      a2_q <= act_2 << lsh;
    end else if (shift) begin
      a1_q <= a1_q << 1;
      a2_q <= a2_q << 1;
    end
  end

  assign msb_1 = a1_q[PREC_MAX-1];
  assign msb_2 = a2_q[PREC_MAX-1];

endmodule

// File: rtl/fsm_nda.sv
// Bit-serial MAC sequencer for a BRAMAC dummy array.
// Define BRAMAC_SIGNED_EN to enable the signed INV/SUB path.
module fsm_nda
  import bramac_pkg::*;
#(
  parameter int PREC_MAX = 8,
  parameter int PW       = $clog2(PREC_MAX) + 1
) (
  input  logic                clk,
  input  logic                reset_bram_n,
  input  logic                comp_en,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic                inst_flush,
  input  logic                inst_signed,
  input  logic                inst_last,
  input  logic [PW-1:0]       inst_prec,
  input  logic [PREC_MAX-1:0] inst_act_1,
  input  logic [PREC_MAX-1:0] inst_act_2,
  output logic                carry_in,
  output logic                ren_1,
  output logic                ren_2,
  output logic                wen_1,
  output logic                wen_2,
  output logic                readout,
  output logic                busy,
  output logic [2:0]          raddr_1,
  output logic [2:0]          raddr_2,
  output logic [2:0]          waddr_1,
  output logic [2:0]          waddr_2,
  output logic [1:0]          wsel_1,
  output logic [1:0]          wsel_2,
  output logic                mac_done
);

`ifdef BRAMAC_SIGNED_EN
  localparam logic SIGN_EN = 1'b1;
`else
  localparam logic SIGN_EN = 1'b0;
`endif

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic [PW-1:0] prec_q;
  logic [PW-1:0] prec_c;
  logic          signed_q;
  logic          last_q;
  logic          accept;
  logic          flush;
  logic          load;
  logic          shift;
  logic          msb_1;
  logic          msb_2;
  logic [2:0]    dec;
  strobes_t      st;

  assign inst_ready = state_q inside {S_IDLE, S_WAIT, S_DONE_2};
  assign busy   = !(state_q inside {S_IDLE, S_WAIT, S_DONE_1, S_DONE_2});
  assign accept = comp_en && inst_valid && inst_ready;
  assign flush  = comp_en && inst_flush;
  assign load   = accept && !flush;
  assign shift  = (state_q inside {S_SUB, S_ASL}) && !flush;
  assign dec    = act_dec(msb_1, msb_2);

  assign prec_c = (inst_prec == '0 || inst_prec > PW'(PREC_MAX))
                ? PW'(PREC_MAX) : inst_prec;

  bramac_act_shreg #(
    .PREC_MAX(PREC_MAX),
    .PW      (PW)
  ) u_shreg (
    .clk  (clk),
    .rst_n(reset_bram_n),
    .load (load),
    .shift(shift),
    .prec (prec_c),
    .act_1(inst_act_1),
    .act_2(inst_act_2),
    .msb_1(msb_1),
    .msb_2(msb_2)
  );

  always_ff @(posedge clk or negedge reset_bram_n) begin
    if (!reset_bram_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prec_q   <= '0;
      signed_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        prec_q   <= prec_c;
        signed_q <= inst_signed & SIGN_EN;
        last_q   <= inst_last;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d    = S_INIT_ACC;
          st.wen_2   = 1'b1;
          st.waddr_2 = ROW_ACC;
          st.wsel_2  = WSEL_ZERO;
        end
      end
      S_INIT_ACC: state_d = S_COPY;
      S_COPY: begin
        state_d    = S_PREADD;
        st.wen_1   = 1'b1;
        st.waddr_1 = ROW_W1;
        st.wsel_1  = WSEL_BRAM;
        st.wen_2   = 1'b1;
        st.waddr_2 = ROW_W2;
        st.wsel_2  = WSEL_BRAM;
      end
      S_PREADD: begin
        state_d    = signed_q ? S_INV : S_BUBBLE;
        cnt_d      = signed_q ? prec_q - PW'(1) : prec_q;
        st.ren_1   = 1'b1;
        st.raddr_1 = ROW_W1;
        st.ren_2   = 1'b1;
        st.raddr_2 = ROW_W2;
        st.wen_1   = 1'b1;
        st.waddr_1 = ROW_W12;
        st.wsel_1  = WSEL_ALU;
        st.wen_2   = 1'b1;
        st.waddr_2 = ROW_PSUM;
        st.wsel_2  = WSEL_ZERO;
      end
      S_BUBBLE: state_d = S_ASL;
      S_INV: begin
        state_d    = S_SUB;
        st.ren_1   = 1'b1;
        st.raddr_1 = dec;
        st.wen_1   = 1'b1;
        st.waddr_1 = ROW_INV;
        st.wsel_1  = WSEL_ALU;
      end
      S_SUB: begin
        // a 1-bit signed operand has no magnitude bits left
        state_d     = (cnt_q == '0) ? S_ACC : S_ASL;
        st.carry_in = 1'b1;
        st.ren_1    = 1'b1;
        st.raddr_1  = ROW_INV;
        st.ren_2    = 1'b1;
        st.raddr_2  = ROW_PSUM;
        st.wen_2    = 1'b1;
        st.waddr_2  = ROW_PSUM;
        st.wsel_2   = WSEL_ALU;
      end
      S_ASL: begin
        state_d    = (cnt_q <= PW'(1)) ? S_ACC : S_ASL;
        cnt_d      = cnt_q - PW'(1);
        st.ren_1   = 1'b1;
        st.raddr_1 = dec;
        st.ren_2   = 1'b1;
        st.raddr_2 = ROW_PSUM;
        st.wen_2   = 1'b1;
        st.waddr_2 = ROW_PSUM;
        st.wsel_2  = WSEL_ALU;
      end
      S_ACC: begin
        state_d     = last_q ? S_DONE_1 : S_WAIT;
        st.mac_done = 1'b1;
        st.ren_1    = 1'b1;
        st.raddr_1  = ROW_PSUM;
        st.ren_2    = 1'b1;
        st.raddr_2  = ROW_ACC;
        st.wen_2    = 1'b1;
        st.waddr_2  = ROW_ACC;
        st.wsel_2   = WSEL_ALU;
      end
      S_WAIT: begin
        if (load) state_d = S_COPY;
      end
      S_DONE_1: state_d = S_DONE_2;
      S_DONE_2: begin
        st.readout = 1'b1;
        st.ren_2   = 1'b1;
        st.raddr_2 = ROW_ACC;
        if (load) begin
          state_d    = S_COPY;
          st.wen_2   = 1'b1;
          st.waddr_2 = ROW_ACC;
          st.wsel_2  = WSEL_ZERO;
        end else begin
          state_d = S_DONE_1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign carry_in = st.carry_in;
  assign ren_1    = st.ren_1;
  assign ren_2    = st.ren_2;
  assign wen_1    = st.wen_1;
  assign wen_2    = st.wen_2;
  assign readout  = st.readout;
  assign mac_done = st.mac_done;
  assign raddr_1  = st.raddr_1;
  assign raddr_2  = st.raddr_2;
  assign waddr_1  = st.waddr_1;
  assign waddr_2  = st.waddr_2;
  assign wsel_1   = st.wsel_1;
  assign wsel_2   = st.wsel_2;

endmodule

// File: tb/tb_fsm_nda.sv
// Bench for fsm_nda: a cycle table for one full MAC plus
// transaction-level checks of directed and random MACs.
module tb_fsm_nda;

  localparam int PREC_MAX = 8;
  localparam int PW       = $clog2(PREC_MAX) + 1;
`ifdef BRAMAC_SIGNED_EN
  localparam int SIGN_EN = 1;
`else
  localparam int SIGN_EN = 0;
`endif
  localparam int WZ = 1;
  localparam int WB = 2;
  localparam int WA = 3;

  logic                clk = 1'b0;
  logic                reset_bram_n = 1'b0;
  logic                comp_en = 1'b0;
  logic                inst_valid = 1'b0;
  logic                inst_flush = 1'b0;
  logic                inst_signed = 1'b0;
  logic                inst_last = 1'b0;
  logic [PW-1:0]       inst_prec = '0;
  logic [PREC_MAX-1:0] inst_act_1 = '0;
  logic [PREC_MAX-1:0] inst_act_2 = '0;
  logic                inst_ready;
  logic                carry_in, ren_1, ren_2, wen_1, wen_2;
  logic                readout, busy, mac_done;
  logic [2:0]          raddr_1, raddr_2, waddr_1, waddr_2;
  logic [1:0]          wsel_1, wsel_2;

  int n_run  = 0;
  int n_fail = 0;
  int ph     = 0;

  always #5 clk = ~clk;

  fsm_nda #(.PREC_MAX(PREC_MAX)) dut (
    .clk         (clk),
    .reset_bram_n(reset_bram_n),
    .comp_en     (comp_en),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_flush  (inst_flush),
    .inst_signed (inst_signed),
    .inst_last   (inst_last),
    .inst_prec   (inst_prec),
    .inst_act_1  (inst_act_1),
    .inst_act_2  (inst_act_2),
    .carry_in    (carry_in),
    .ren_1       (ren_1),
    .ren_2       (ren_2),
    .wen_1       (wen_1),
    .wen_2       (wen_2),
    .readout     (readout),
    .busy        (busy),
    .raddr_1     (raddr_1),
    .raddr_2     (raddr_2),
    .waddr_1     (waddr_1),
    .waddr_2     (waddr_2),
    .wsel_1      (wsel_1),
    .wsel_2      (wsel_2),
    .mac_done    (mac_done)
  );

  typedef struct packed {
    logic       rdy, bsy, rd, dn, cin;
    logic       r1;
    logic [2:0] a1;
    logic       r2;
    logic [2:0] a2;
    logic       w1;
    logic [2:0] wa1;
    logic [1:0] s1;
    logic       w2;
    logic [2:0] wa2;
    logic [1:0] s2;
  } obs_t;

  typedef struct {
    logic en, valid, flush;
    obs_t exp;
  } vec_t;

  vec_t vt[$];

  function automatic obs_t ob(
    input int rdy, bsy, rd, dn, cin,
    input int r1, a1, r2, a2,
    input int w1, wa1, s1, w2, wa2, s2
  );
    obs_t o;
    o.rdy = rdy[0]; o.bsy = bsy[0]; o.rd = rd[0];
    o.dn = dn[0]; o.cin = cin[0];
    o.r1 = r1[0]; o.a1 = a1[2:0];
    o.r2 = r2[0]; o.a2 = a2[2:0];
    o.w1 = w1[0]; o.wa1 = wa1[2:0]; o.s1 = s1[1:0];
    o.w2 = w2[0]; o.wa2 = wa2[2:0]; o.s2 = s2[1:0];
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.rdy = inst_ready; o.bsy = busy; o.rd = readout;
    o.dn = mac_done; o.cin = carry_in;
    o.r1 = ren_1; o.a1 = raddr_1;
    o.r2 = ren_2; o.a2 = raddr_2;
    o.w1 = wen_1; o.wa1 = waddr_1; o.s1 = wsel_1;
    o.w2 = wen_2; o.wa2 = waddr_2; o.s2 = wsel_2;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, valid, flush, input obs_t e);
    vec_t v;
    v.en = en; v.valid = valid; v.flush = flush; v.exp = e;
    vt.push_back(v);
  endtask

  // Drives one instruction and follows it to its mac_done.
  task automatic run_mac(input int prec, input logic [7:0] a1, a2,
                         input bit sgn, last, hold, input string tg);
    int p, s, nasl, idx, copy_at, gap, lat, n_rdy, n_clr;
    int n_cin, inv_ra, nobusy, bad;
    bit acc, done, rd_acc;
    int q_exp[$];
    int q_got[$];
    p = (prec == 0 || prec > PREC_MAX) ? PREC_MAX : prec;
    s = (sgn && SIGN_EN != 0) ? 1 : 0;
    nasl = p - s;
    for (int k = 0; k < nasl; k++) begin
      idx = p - 1 - s - k;
      q_exp.push_back(2 * int'(a2[idx]) + int'(a1[idx]));
    end
    inst_prec = PW'(prec); inst_act_1 = a1; inst_act_2 = a2;
    inst_signed = sgn; inst_last = last;
    inst_valid = 1'b1; comp_en = 1'b1; inst_flush = 1'b0;
    acc = 0; done = 0; rd_acc = 0; copy_at = -1; gap = 0; lat = 0;
    n_rdy = 0; n_clr = 0; n_cin = 0; inv_ra = -1; nobusy = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (wen_2 && waddr_2 == 3'd6 && wsel_2 == 2'(WZ)) n_clr++;
      if (!acc) begin
        if (inst_ready) n_rdy++;
        if (inst_ready && inst_valid && comp_en) begin
          acc = 1; rd_acc = readout;
        end
      end else begin
        if (copy_at < 0) begin
          if (wen_1 && waddr_1 == 3'd1 && wsel_1 == 2'(WB)) copy_at = c;
          else gap++;
        end
        if (copy_at >= 0 && !busy) nobusy++;
        if (carry_in) n_cin++;
        if (wen_1 && waddr_1 == 3'd4) inv_ra = int'(raddr_1);
        if (wen_2 && waddr_2 == 3'd5 && wsel_2 == 2'(WA) && !carry_in)
          q_got.push_back(int'(raddr_1));
        if (mac_done) begin
          lat = c - copy_at + 1; done = 1;
        end
      end
      @(posedge clk); #1;
      if (acc && !hold) inst_valid = 1'b0;
    end
    if (!done) begin
      n_run++; n_fail++;
      $display("FAIL %s_timeout: got no mac_done expected one", tg);
      return;
    end
    bad = 0;
    for (int k = 0; k < q_exp.size() && k < q_got.size(); k++)
      if (q_got[k] != q_exp[k]) bad++;
    chk({tg, "_rdy"}, n_rdy, 1);
    chk({tg, "_gap"}, gap, (ph == 0) ? 1 : 0);
    chk({tg, "_clr"}, n_clr, (ph != 1) ? 1 : 0);
    chk({tg, "_rd"}, rd_acc, (ph == 2) ? 1 : 0);
    chk({tg, "_lat"}, lat, p + 4);
    chk({tg, "_nasl"}, q_got.size(), nasl);
    chk({tg, "_aslseq"}, bad, 0);
    chk({tg, "_cin"}, n_cin, s);
    chk({tg, "_inv"}, inv_ra,
        s != 0 ? 2 * int'(a2[p-1]) + int'(a1[p-1]) : -1);
    chk({tg, "_busy"}, nobusy, 0);
    #1;
    chk({tg, "_done1"}, mac_done, 0);
    ph = last ? 2 : 1;
  endtask

  // Idle IDLE/after-reset output pattern.
  obs_t idle_o;
  obs_t zero_b;

  initial begin
    bit hit;
    idle_o = ob(1,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
    zero_b = ob(0,1,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);

    add(1,1,0, ob(1,0,0,0,0, 0,0, 0,0, 0,0,0, 1,6,WZ));
    add(1,0,0, zero_b);
    add(1,0,0, ob(0,1,0,0,0, 0,0, 0,0, 1,1,WB, 1,2,WB));
    add(1,0,0, ob(0,1,0,0,0, 1,1, 1,2, 1,3,WA, 1,5,WZ));
    add(1,0,0, zero_b);
    add(1,0,0, ob(0,1,0,0,0, 1,1, 1,5, 0,0,0, 1,5,WA));
    add(1,0,0, ob(0,1,0,0,0, 1,2, 1,5, 0,0,0, 1,5,WA));
    add(1,0,0, ob(0,1,0,0,0, 1,3, 1,5, 0,0,0, 1,5,WA));
    add(1,0,0, ob(0,1,0,0,0, 1,1, 1,5, 0,0,0, 1,5,WA));
    add(1,0,0, ob(0,1,0,1,0, 1,5, 1,6, 0,0,0, 1,6,WA));
    add(1,0,0, ob(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0));
    add(1,0,0, ob(1,0,1,0,0, 0,0, 1,6, 0,0,0, 0,0,0));
    add(1,0,0, ob(0,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0));
    add(1,1,0, ob(1,0,1,0,0, 0,0, 1,6, 0,0,0, 1,6,WZ));
    add(1,0,0, ob(0,1,0,0,0, 0,0, 0,0, 1,1,WB, 1,2,WB));
    add(1,0,0, ob(0,1,0,0,0, 1,1, 1,2, 1,3,WA, 1,5,WZ));
    add(1,0,0, zero_b);
    add(1,0,1, ob(0,1,0,0,0, 1,1, 1,5, 0,0,0, 1,5,WA));
    add(1,0,0, idle_o);
    add(0,1,0, idle_o);
    add(0,1,0, idle_o);
    add(1,0,0, idle_o);

    #2;
    chk("reset_out", cur(), idle_o);
    @(posedge clk); #1;
    reset_bram_n = 1'b1;

    inst_prec = PW'(4); inst_act_1 = 8'b0000_1011;
    inst_act_2 = 8'b0000_0110; inst_signed = 1'b0; inst_last = 1'b1;
    foreach (vt[i]) begin
      comp_en = vt[i].en; inst_valid = vt[i].valid;
      inst_flush = vt[i].flush;
      #1;
      chk($sformatf("vec%0d", i), cur(), vt[i].exp);
      @(posedge clk); #1;
    end
    inst_valid = 1'b0; inst_flush = 1'b0; comp_en = 1'b1;

    ph = 0;
    run_mac(5, 8'h13, 8'h0A, 0, 0, 1, "b2b_a");
    run_mac(3, 8'h05, 8'h02, 0, 0, 1, "b2b_b");
    run_mac(8, 8'hA5, 8'h3C, 0, 0, 0, "b2b_c");
    run_mac(8, 8'h80, 8'hFF, 1, 0, 0, "signed8");
    run_mac(0, 8'h6D, 8'hB2, 0, 0, 0, "prec0");
    run_mac(9, 8'h6D, 8'hB2, 0, 1, 0, "prec9");
    run_mac(6, 8'h21, 8'h3F, 1, 0, 0, "signed6");

    inst_prec = PW'(8); inst_act_1 = 8'h80; inst_act_2 = 8'hFF;
    inst_signed = 1'b1; inst_last = 1'b0; inst_valid = 1'b1;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      #1;
      if (SIGN_EN != 0) hit = carry_in;
      else hit = wen_2 && waddr_2 == 3'd5 && wsel_2 == 2'(WA);
      if (!hit) begin
        @(posedge clk); #1;
        inst_valid = 1'b0;
      end
    end
    if (!hit) begin
      n_run++; n_fail++;
      $display("FAIL rst_mid_timeout: got no SUB/ASL expected one");
    end
    inst_valid = 1'b0;
    reset_bram_n = 1'b0;
    #1;
    chk("rst_async", cur(), idle_o);
    @(posedge clk); #1;
    chk("rst_held", cur(), idle_o);
    reset_bram_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after", cur(), idle_o);
    ph = 0;

    for (int i = 0; i < 30; i++) begin
      run_mac(int'($urandom_range(0, 15)),
              8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom),
              $sformatf("rnd%0d", i));
    end
    inst_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_nda.md
FSM_NDA -- requirements
Module: fsm_nda

Interface
REQ-001 PREC_MAX, 8, maximum activation precision in bits; power of two, 2..16.
REQ-002 PW, $clog2(PREC_MAX)+1, width of prec field.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_bram_n  in  1  asynchronous active-low reset.
REQ-005 comp_en  in  1  M20K in compute mode; all inst_* inputs are ignored when low.
REQ-006 inst_valid  in  1  instruction present.
REQ-007 inst_ready  out  1  block can accept an instruction this cycle.
REQ-008 inst_flush  in  1  synchronous abort to IDLE (qualified by comp_en, no handshake needed).
REQ-009 inst_signed  in  1  activations are two's complement.
REQ-010 inst_last  in  1  last MAC of the accumulation.
REQ-011 inst_prec  in  PW  activation bit count P.
REQ-012 inst_act_1, inst_act_2  in  PREC_MAX each  right-aligned activations.
REQ-013 carry_in, ren_1, ren_2, wen_1, wen_2, readout, busy  out  1 each  dummy-array strobes / status.
REQ-014 raddr_1, raddr_2, waddr_1, waddr_2  out  3 each  dummy row address.
REQ-015 wsel_1, wsel_2  out  2 each  write mux selects.
REQ-016 mac_done  out  1  one-cycle pulse on each ACC cycle.

Function
REQ-017 Accept = comp_en && inst_valid && inst_ready; inst_ready high only in IDLE, WAIT, DONE_2.
REQ-018 States: IDLE, INIT_ACC, COPY, PREADD, BUBBLE, INV, SUB, ASL, ACC, WAIT, DONE_1, DONE_2.
REQ-019 IDLE: accept -> INIT_ACC (wen_2=1, waddr_2=acc, wsel_2=zero); all other strobes 0.
REQ-020 INIT_ACC->COPY->PREADD; PREADD -> INV if signed_q else BUBBLE; INV->SUB; SUB and BUBBLE -> ASL.
REQ-021 Unsigned: P ASL cycles; signed: SUB handles the MSB, then P-1 ASL cycles; last ASL -> ACC; MAC latency COPY..ACC = P+4 cycles in both modes.
REQ-022 ACC: last_q -> DONE_1; else -> WAIT; mac_done=1.
REQ-023 WAIT: accept -> COPY with new operands latched; all strobes 0.
REQ-024 DONE_1 -> DONE_2; DONE_2: readout=1, ren_2=1, raddr_2=acc; accept -> COPY plus acc cleared (wen_2=1, waddr_2=acc, wsel_2=zero); else -> DONE_1.
REQ-025 Row addresses: zero 0, w1 1, w2 2, w12 3, inv 4, psum 5, acc 6; act_dec = {0, act2_msb, act1_msb}.
REQ-026 COPY writes w1/w2 from BRAM; PREADD writes w12 and clears psum; INV writes ~row(act_dec) to inv; SUB psum += inv with carry_in=1; ASL psum = (psum<<1)+row(act_dec); ACC acc += psum.
REQ-027 On accept, prec_q = inst_prec clamped: 0 or >PREC_MAX -> PREC_MAX; activations latched left-aligned (shifted by PREC_MAX-P); they shift left 1 after each SUB and ASL.
REQ-028 busy = state not in {IDLE, WAIT, DONE_1, DONE_2}.
REQ-029 inst_flush in any state -> IDLE next cycle, overriding accept; latched operands are unchanged.
REQ-030 Unused addresses and selects drive 0 (no X on outputs).

Reset
REQ-031 Asynchronous reset: state=IDLE, counter=0, latched operands/prec/signed/last = 0, all outputs 0 except inst_ready=1.

Configuration
REQ-032 BRAMAC_SIGNED_EN defined: signed path (INV/SUB) present; undefined: inst_signed ignored, INV/SUB unreachable, always the BUBBLE path.

Structure
REQ-033 Package bramac_pkg holds the state enum, row-address constants and wsel constants.
REQ-034 One sub-module bramac_act_shreg: load/align/shift of both activations, exposes the MSBs.

Verification
REQ-035 Unsigned P=4, act1=4'b1011, act2=4'b0110, last=1 -> raddr_1 in ASL cycles = 1,2,3,1; ACC 8 cycles after COPY; then DONE_1/DONE_2 toggle with readout in DONE_2.
REQ-036 Signed P=8, act1=0x80, act2=0xFF -> INV raddr_1=3, SUB carry_in=1, 7 ASL cycles, mac_done once.
REQ-037 Three back-to-back MACs, inst_valid held high -> ACC->WAIT->COPY each, inst_ready 1 cycle each, INIT_ACC only once.
REQ-038 inst_prec=0 and inst_prec=9 (PREC_MAX=8) -> 8 ASL cycles each.
REQ-039 inst_flush mid-ASL, and reset_bram_n low mid-SUB -> IDLE, all strobes 0 next cycle, inst_ready=1.
REQ-040 comp_en=0 with inst_valid=1 in IDLE -> no transition; DONE_2 accept -> acc cleared and COPY next.
